instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Multi-cycle control FSM for the GAMMA processor core. It fetches 32-bit instructions from instruction memory over a req/ready handshake and holds each one in an instruction register that drives the combinational instruction decoder. It then sequences register read, ALU execute and register writeback from the decoder's format outputs, and owns the PC, halt and trap status.

Parameters:
ADDR_W, 16, PC and instruction-address width.
RESET_PC, 0, PC value loaded at reset.
PC_STEP, 4, PC increment per retired instruction (byte addressing).
MEM_TIMEOUT, 255, max wait cycles on imem_ready (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
imem_req  out  1  instruction read request.
imem_addr  out  ADDR_W  read address; always equals pc.
imem_ready  in  1  rdata valid this cycle.
imem_rdata  in  32  instruction word.
ir  out  32  instruction register; feeds the decoder.
dec_format  in  2  decoder format: 0=a, 1=b, 2=c.
dec_ifnr  in  1  decoder "format not recognized" flag.
rf_rd_en  out  1  register file read strobe (Rsrc1, Rsrc2).
alu_start  out  1  one-cycle ALU start pulse.
alu_src_imm  out  1  1 selects the immediate operand, 0 selects Rsrc2.
alu_done  in  1  ALU result valid.
rf_wr_en  out  1  register file write strobe.
rf_wr_sel  out  1  destination select: 0=Rdst (format a), 1=Rsrc2 (format b).
pc  out  ADDR_W  program counter.
halted  out  1  sticky; halt instruction retired.
trap  out  1  sticky; illegal instruction or memory timeout.
state_dbg  out  3  current state encoding.

Behaviour:
- Reset (async, reset_n=0): state=FETCH, pc=RESET_PC, ir=0; halted, trap and all strobes 0.
- States and encodings: FETCH=0, WAIT_MEM=1, DECODE=2, EXEC=3, WB=4, HALT=5, TRAP=6.
- FETCH: imem_req=1 for 1 cycle, then go to WAIT_MEM.
- WAIT_MEM: imem_req held 1. On imem_ready=1, ir<=imem_rdata, imem_req drops the next cycle, go to DECODE. Otherwise stay.
- DECODE (1 cycle; the decoder settles combinationally from ir):
  - ir==32'hFFFF_FFFF: go to HALT.
  - dec_ifnr=1 or dec_format==3: go to TRAP.
  - Otherwise rf_rd_en=1 and go to EXEC.
- EXEC: alu_start=1 on the first EXEC cycle only. alu_src_imm=1 for format b or c, 0 for format a; it is held for all of EXEC. Wait for alu_done. alu_done asserted in the same cycle as alu_start is accepted.
- WB (1 cycle):
  - rf_wr_en=1 for format a or b, with rf_wr_sel=(format==1).
  - Format c: no write.
  - pc<=pc+PC_STEP, modulo 2^ADDR_W (wraps silently), then go to FETCH.
- Best case: 5 cycles per instruction (FETCH, WAIT_MEM with 0-wait memory, DECODE, EXEC, WB).
- HALT: terminal. halted=1; pc is not advanced; all strobes 0.
- TRAP: terminal. trap=1; pc holds the faulting instruction's address; all strobes 0.
- HALT and TRAP are left only by reset.
- Format and strobe values are registered at DECODE, so a decoder change after DECODE does not affect EXEC or WB.
- Reset asserted mid-operation (any state, including a pending imem handshake) aborts immediately. There is no retry bookkeeping; fetch restarts at RESET_PC.

Optional Feature:
SEQ_MEM_TIMEOUT_EN
- Defined: an 8-bit (or wider) counter clears on entry to WAIT_MEM and increments each cycle without imem_ready. When it reaches MEM_TIMEOUT, go to TRAP with trap=1 and drop imem_req.
- Undefined: WAIT_MEM waits indefinitely; no counter logic is present.

Decomposition:
- Shared package/include instr_seq_defs holds:
  - state encodings;
  - format codes FMT_A=0, FMT_B=1, FMT_C=2;
  - the HALT_WORD=32'hFFFF_FFFF constant.
  The decoder includes the same format codes.
- No sub-module. Optionally factor out pc_reg (PC register plus incrementer).

Test Plan:
- Reset, then 0-wait memory returning a format-a word (low 6 bits 000000) -> imem_req is seen at cycle 1; rf_wr_en=1 with rf_wr_sel=0 at cycle 5; pc goes 0 -> 4.
- Format-b word (low 6 bits 100010), alu_done 3 cycles after alu_start -> alu_src_imm=1 throughout EXEC; rf_wr_sel=1; WB occurs on the cycle after alu_done; pc=4.
- dec_ifnr forced to 1 on the second instruction -> TRAP; trap=1; pc stays 4; no rf_wr_en pulse; stays put for 20 cycles.
- imem_rdata=32'hFFFF_FFFF at pc=8 -> HALT; halted=1; pc=8; no further imem_req.
- reset_n pulsed low during EXEC -> all outputs go to reset values asynchronously; after release, the fetch address is RESET_PC.
- With SEQ_MEM_TIMEOUT_EN and MEM_TIMEOUT=10, imem_ready held 0 -> TRAP after 10 WAIT_MEM cycles; without the macro, still in WAIT_MEM after 1000 cycles.

Source files
------------

// File: rtl/instr_seq_defs.sv
// Shared definitions for the GAMMA instruction sequencer and its decoder:
// state encodings, instruction format codes and the halt word.
package instr_seq_defs;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_WAIT_MEM = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_WB       = 3'd4,
    S_HALT     = 3'd5,
    S_TRAP     = 3'd6
  } state_t;

  localparam logic [1:0]  FMT_A     = 2'd0;
  localparam logic [1:0]  FMT_B     = 2'd1;
  localparam logic [1:0]  FMT_C     = 2'd2;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback control FSM for the GAMMA core.
// Define SEQ_MEM_TIMEOUT_EN to trap when imem_ready stalls for MEM_TIMEOUT cycles.
module instr_sequencer
  import instr_seq_defs::*;
#(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                PC_STEP     = 4,
  parameter int                MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  input  logic [1:0]        dec_format,
  input  logic              dec_ifnr,
  output logic              rf_rd_en,
  output logic              alu_start,
  output logic              alu_src_imm,
  input  logic              alu_done,
  output logic              rf_wr_en,
  output logic              rf_wr_sel,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              trap,
  output logic [2:0]        state_dbg
);

  state_t     state, state_nx;
  logic [1:0] fmt_q;
  logic       exec_first;
  logic       req_c;
  logic       to_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      fmt_q      <= FMT_A;
      exec_first <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_WAIT_MEM && imem_ready) ir <= imem_rdata;
      // Format is frozen here so later decoder activity cannot disturb EXEC/WB.
      if (state == S_DECODE) begin
        fmt_q      <= dec_format;
        exec_first <= 1'b1;
      end else if (state == S_EXEC) begin
        exec_first <= 1'b0;
      end
      if (state == S_WB) pc <= pc + ADDR_W'(PC_STEP);
    end
  end

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int TO_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              to_cnt <= '0;
    else if (state == S_FETCH)                 to_cnt <= '0;
    else if (state == S_WAIT_MEM && !imem_ready) to_cnt <= to_cnt + TO_W'(1);
  end

  assign to_hit = (to_cnt + TO_W'(1)) == TO_W'(MEM_TIMEOUT);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    req_c       = 1'b0;
    rf_rd_en    = 1'b0;
    alu_start   = 1'b0;
    alu_src_imm = 1'b0;
    rf_wr_en    = 1'b0;
    rf_wr_sel   = 1'b0;
    case (state)
      S_FETCH: begin
        req_c    = 1'b1;
        state_nx = S_WAIT_MEM;
      end
      S_WAIT_MEM: begin
        req_c = 1'b1;
        if (imem_ready)  state_nx = S_DECODE;
        else if (to_hit) state_nx = S_TRAP;
      end
      S_DECODE: begin
        if (ir == HALT_WORD)                    state_nx = S_HALT;
        else if (dec_ifnr || dec_format == 2'd3) state_nx = S_TRAP;
        else begin
          rf_rd_en = 1'b1;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_start   = exec_first;
        alu_src_imm = (fmt_q != FMT_A);
        if (alu_done) state_nx = S_WB;
      end
      S_WB: begin
        rf_wr_en  = (fmt_q != FMT_C);
        rf_wr_sel = (fmt_q == FMT_B);
        state_nx  = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_FETCH;
    endcase
  end

  // The reset state is FETCH, so qualify the request to keep it low while reset is held.
  assign imem_req  = req_c & reset_n;
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);
  assign trap      = (state == S_TRAP);
  assign state_dbg = state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: memory, decoder and ALU models drive the
// DUT; legal fetches push expected writebacks, popped and compared at WB.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [1:0]  dec_format;
  logic        dec_ifnr;
  logic        rf_rd_en, alu_start, alu_src_imm, alu_done, rf_wr_en, rf_wr_sel;
  logic [15:0] pc;
  logic        halted, trap;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .PC_STEP(4), .MEM_TIMEOUT(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir(ir), .dec_format(dec_format), .dec_ifnr(dec_ifnr),
    .rf_rd_en(rf_rd_en), .alu_start(alu_start), .alu_src_imm(alu_src_imm), .alu_done(alu_done),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel),
    .pc(pc), .halted(halted), .trap(trap), .state_dbg(state_dbg)
  );

  localparam logic [31:0] W_A    = 32'h0012_3400;  // low 6 = 000000
  localparam logic [31:0] W_B    = 32'h00AB_CD22;  // low 6 = 100010
  localparam logic [31:0] W_C    = 32'h0000_0043;  // low 6 = 000011
  localparam logic [31:0] W_F3   = 32'h0000_0033;  // low 6 = 110011 -> format 3
  localparam logic [31:0] W_HALT = 32'hFFFF_FFFF;

  typedef struct {
    logic [1:0]  fmt;
    logic [15:0] addr;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] mem [16];
  int          lat_tab [16];
  int          waits, wcnt;
  bit          mem_en, force_ifnr;
  int          n_chk, n_pass;
  int          exec_cyc, starts, wr_cnt;
  logic        prev_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Bench decoder: {ifnr, format}
  function automatic logic [2:0] tdec(input logic [31:0] w);
    case (w[5:0])
      6'b000000: return 3'b0_00;
      6'b100010: return 3'b0_01;
      6'b000011: return 3'b0_10;
      6'b110011: return 3'b0_11;
      default:   return 3'b1_00;
    endcase
  endfunction

  function automatic bit legal(input logic [31:0] w, input logic [15:0] a);
    logic [2:0] d;
    d = tdec(w);
    return (w != W_HALT) && !d[2] && (d[1:0] != 2'd3) && !(force_ifnr && a == 16'd4);
  endfunction

  logic [2:0] dq;
  assign dq         = tdec(ir);
  assign dec_ifnr   = dq[2] | (force_ifnr && pc == 16'd4);
  // Decoder output goes bad after DECODE; the DUT must have latched the format.
  assign dec_format = (state_dbg == 3'd3 || state_dbg == 3'd4) ? 2'd3 : dq[1:0];

  // ALU model: done lat cycles after start (lat 0 = same cycle)
  logic busy;
  int   acnt, cur_lat;
  assign cur_lat  = lat_tab[pc[5:2]];
  assign alu_done = (alu_start && cur_lat == 0) || (busy && acnt == cur_lat);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      acnt <= 0;
    end else if (alu_start && !alu_done) begin
      busy <= 1'b1;
      acnt <= 1;
    end else if (busy) begin
      if (alu_done) busy <= 1'b0;
      else          acnt <= acnt + 1;
    end
  end

  // Memory model: answers in WAIT_MEM after `waits` stall cycles
  always @(negedge clk) begin
    logic [2:0] d;
    if (reset_n && state_dbg == 3'd1 && imem_req && mem_en) begin
      if (wcnt >= waits) begin
        imem_ready = 1'b1;
        imem_rdata = mem[imem_addr[5:2]];
        wcnt       = 0;
        if (legal(imem_rdata, imem_addr)) begin
          d = tdec(imem_rdata);
          sb.push_back('{fmt: d[1:0], addr: imem_addr, lat: lat_tab[imem_addr[5:2]]});
        end
      end else begin
        imem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ready = 1'b0;
      wcnt       = 0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (reset_n) begin
      case (state_dbg)
        3'd2: begin
          chk("rd_en", 32'(rf_rd_en), 32'(sb.size() != 0));
          exec_cyc = 0;
          starts   = 0;
        end
        3'd3: begin
          exec_cyc++;
          if (alu_start) starts++;
          if (sb.size() != 0) chk("src_imm", 32'(alu_src_imm), 32'(sb[0].fmt != 2'd0));
          prev_done = alu_done;
        end
        3'd4: begin
          if (sb.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("wb_wr_en", 32'(rf_wr_en), 32'(e.fmt != 2'd2));
            if (e.fmt != 2'd2) chk("wb_sel", 32'(rf_wr_sel), 32'(e.fmt == 2'd1));
            chk("wb_pc", 32'(pc), 32'(e.addr));
            chk("exec_len", 32'(exec_cyc), 32'(e.lat + 1));
            chk("alu_starts", 32'(starts), 32'd1);
            chk("wb_after_done", 32'(prev_done), 32'd1);
          end
        end
        default: ;
      endcase
      if (rf_wr_en) wr_cnt++;
      if (rf_wr_en && state_dbg != 3'd4) chk("wr_stray", 32'd1, 32'd0);
    end
  end

  task automatic wait_st(input logic [2:0] s, input int lim, input string tag);
    int n = 0;
    while (state_dbg != s && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state_dbg), 32'(s));
  endtask

  task automatic hold_reset();
    @(negedge clk);
    #3 reset_n = 1'b0;
    sb.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    #3 reset_n = 1'b1;
  endtask

  task automatic load(input logic [31:0] w0, w1, w2, input int l0, l1, l2);
    for (int i = 0; i < 16; i++) begin
      mem[i]     = W_HALT;
      lat_tab[i] = 0;
    end
    mem[0] = w0; mem[1] = w1; mem[2] = w2;
    lat_tab[0] = l0; lat_tab[1] = l1; lat_tab[2] = l2;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    mem_en = 1'b1; waits = 0; wcnt = 0; force_ifnr = 1'b0;
    n_chk = 0; n_pass = 0; wr_cnt = 0; exec_cyc = 0; starts = 0; prev_done = 1'b0;
    load(W_A, W_B, W_HALT, 0, 3, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_strobes", 32'({rf_rd_en, alu_start, alu_src_imm, rf_wr_en}), 32'd0);

    // A then B (ALU latency 3) then HALT at pc 8
    #2 reset_n = 1'b1;
    #1;
    chk("req_c1", 32'(imem_req), 32'd1);
    chk("addr_c1", 32'(imem_addr), 32'd0);
    repeat (4) @(negedge clk);
    chk("wr_c5", 32'(rf_wr_en), 32'd1);
    chk("sel_c5", 32'(rf_wr_sel), 32'd0);
    @(negedge clk);
    chk("pc_c6", 32'(pc), 32'd4);
    wait_st(3'd5, 100, "halt_reach");
    chk("halted", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd8);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req) n++;
    end
    chk("halt_noreq", 32'(n), 32'd0);
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("sb_drain1", 32'(sb.size()), 32'd0);

    // Illegal second instruction via forced ifnr
    hold_reset();
    load(W_A, W_B, W_HALT, 0, 0, 0);
    force_ifnr = 1'b1;
    wr_cnt = 0;
    release_reset();
    wait_st(3'd6, 100, "trap_reach");
    chk("trap_pc", 32'(pc), 32'd4);
    repeat (20) @(negedge clk);
    chk("trap_stay", 32'(state_dbg), 32'd6);
    chk("trap_flag", 32'(trap), 32'd1);
    chk("trap_pc_hold", 32'(pc), 32'd4);
    chk("trap_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("trap_req", 32'(imem_req), 32'd0);
    chk("trap_nohalt", 32'(halted), 32'd0);
    chk("sb_drain2", 32'(sb.size()), 32'd0);

    // Format c (no write), waited memory, then format 3 trap at pc 8
    hold_reset();
    force_ifnr = 1'b0;
    waits = 2;
    load(W_C, W_A, W_F3, 1, 2, 0);
    wr_cnt = 0;
    release_reset();
    wait_st(3'd6, 200, "f3_trap_reach");
    chk("f3_trap_pc", 32'(pc), 32'd8);
    chk("f3_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("sb_drain3", 32'(sb.size()), 32'd0);

    // Async reset in the middle of EXEC
    hold_reset();
    waits = 0;
    load(W_A, W_B, W_HALT, 0, 5, 0);
    release_reset();
    n = 0;
    while (!(state_dbg == 3'd3 && pc == 16'd4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("exec_reach", 32'(state_dbg), 32'd3);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state_dbg), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_ir", ir, 32'd0);
    chk("mid_rst_out", 32'({imem_req, rf_rd_en, alu_start, alu_src_imm, rf_wr_en}), 32'd0);
    sb.delete();
    @(negedge clk);
    #3 reset_n = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd1);
    wait_st(3'd5, 200, "rerun_halt");
    chk("rerun_pc", 32'(pc), 32'd8);
    chk("sb_drain4", 32'(sb.size()), 32'd0);

    // Memory never answers
    hold_reset();
    mem_en = 1'b0;
    release_reset();
`ifdef SEQ_MEM_TIMEOUT_EN
    n = 0;
    for (int k = 0; k < 100 && state_dbg != 3'd6; k++) begin
      @(negedge clk);
      if (state_dbg == 3'd1) n++;
    end
    chk("to_state", 32'(state_dbg), 32'd6);
    chk("to_wait_cycles", 32'(n), 32'd10);
    chk("to_trap", 32'(trap), 32'd1);
    chk("to_req", 32'(imem_req), 32'd0);
`else
    repeat (1000) @(negedge clk);
    chk("nto_state", 32'(state_dbg), 32'd1);
    chk("nto_req", 32'(imem_req), 32'd1);
    chk("nto_trap", 32'(trap), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
